// File: rtl/mod_arith_pkg.sv
// Shared constants for the modular arithmetic datapath: default modulus, width and op encoding.
package mod_arith_pkg;

    localparam int unsigned W_DEFAULT = 32;
    localparam logic [31:0] P_DEFAULT = 32'hFFFF_FFFB;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/mod_addsub_pipe_if.sv
// Valid/ready transaction bus of the modular add/subtract pipeline.
interface mod_addsub_pipe_if
    import mod_arith_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned LANES = 4,
    parameter int unsigned TAGW  = 4
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic                   in_op;
    logic [TAGW-1:0]        in_tag;
    logic [LANES*W-1:0]     in_f;
    logic [LANES*2*W-1:0]   in_z;
    logic [LANES*W-1:0]     in_d;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*W-1:0]     out_r;
    logic [TAGW-1:0]        out_tag;
    logic [LANES-1:0]       out_err;

    modport master (
        output in_valid, in_op, in_tag, in_f, in_z, in_d, out_ready,
        input  in_ready, out_valid, out_r, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_op, in_tag, in_f, in_z, in_d, out_ready,
        output in_ready, out_valid, out_r, out_tag, out_err
    );

endinterface

// File: rtl/mod_addsub_lane.sv
// Per-lane combinational arithmetic: S1 computes (f + z_lo) mod P, S2 applies -d or +d mod P.
module mod_addsub_lane
    import mod_arith_pkg::*;
#(
    parameter int unsigned  W = W_DEFAULT,
    parameter logic [W-1:0] P = W'(P_DEFAULT)
) (
    // S1 side
    input  logic [W-1:0] f_i,
    input  logic [W-1:0] z_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] s1_o,
    output logic         range_err_o,
    // S2 side
    input  logic [W-1:0] s1_i,
    input  logic [W-1:0] d2_i,
    input  logic         op_i,
    output logic [W-1:0] r_o
);

    localparam logic [W:0] PExt = {1'b0, P};

    logic [W:0] sum;
    logic [W:0] t;

    always_comb begin
        sum         = {1'b0, f_i} + {1'b0, z_i};
        s1_o        = (sum >= PExt) ? W'(sum - PExt) : sum[W-1:0];
        range_err_o = (f_i >= P) | (z_i >= P) | (d_i >= P);
    end

    // t[W] is the borrow in subtract mode, the carry in add mode.
    always_comb begin
        if (op_i == OP_ADD) begin
            t   = {1'b0, s1_i} + {1'b0, d2_i};
            r_o = (t >= PExt) ? W'(t - PExt) : t[W-1:0];
        end else begin
            t   = {1'b0, s1_i} - {1'b0, d2_i};
            r_o = t[W] ? W'(t + PExt) : t[W-1:0];
        end
    end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage multi-lane modular add/subtract with valid/ready backpressure and tag passthrough.
module mod_addsub_pipe
    import mod_arith_pkg::*;
#(
    parameter int unsigned  W     = W_DEFAULT,
    parameter logic [W-1:0] P     = W'(P_DEFAULT),
    parameter int unsigned  LANES = 4,
    parameter int unsigned  TAGW  = 4
) (
    input logic              clk,
    input logic              reset,
    mod_addsub_pipe_if.slave pipe_io
);

    logic [LANES-1:0][W-1:0] s1_d;
    logic [LANES-1:0][W-1:0] s1_q;
    logic [LANES-1:0][W-1:0] d_q;
    logic [LANES-1:0][W-1:0] r_d;
    logic [LANES-1:0][W-1:0] r_q;
    logic [LANES-1:0]        err1_d;
    logic [LANES-1:0]        err1_q;
    logic [LANES-1:0]        err2_q;
    logic                    op_q;
    logic [TAGW-1:0]         tag1_q;
    logic [TAGW-1:0]         tag2_q;
    logic                    s1_valid_d;
    logic                    s1_valid_q;
    logic                    out_valid_d;
    logic                    out_valid_q;
    logic                    s1_adv;
    logic                    in_ready;
    logic                    accept;
    logic                    unused_z;

    // Only the low W bits of each multiplier-width z lane take part.
    assign unused_z = ^pipe_io.in_z;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mod_addsub_lane #(
            .W (W),
            .P (P)
        ) u_lane (
            .f_i         (pipe_io.in_f[i*W +: W]),
            .z_i         (pipe_io.in_z[i*2*W +: W]),
            .d_i         (pipe_io.in_d[i*W +: W]),
            .s1_o        (s1_d[i]),
            .range_err_o (err1_d[i]),
            .s1_i        (s1_q[i]),
            .d2_i        (d_q[i]),
            .op_i        (op_q),
            .r_o         (r_d[i])
        );
    end

    always_comb begin
        s1_adv      = s1_valid_q && (!out_valid_q || pipe_io.out_ready);
        in_ready    = !s1_valid_q || s1_adv;
        accept      = pipe_io.in_valid && in_ready;
        s1_valid_d  = accept ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
        out_valid_d = s1_adv ? 1'b1 :
                      ((out_valid_q && pipe_io.out_ready) ? 1'b0 : out_valid_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            d_q         <= '0;
            op_q        <= 1'b0;
            tag1_q      <= '0;
            err1_q      <= '0;
            r_q         <= '0;
            tag2_q      <= '0;
            err2_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                s1_q   <= s1_d;
                d_q    <= pipe_io.in_d;
                op_q   <= pipe_io.in_op;
                tag1_q <= pipe_io.in_tag;
                err1_q <= err1_d;
            end
            if (s1_adv) begin
                r_q    <= r_d;
                tag2_q <= tag1_q;
                err2_q <= err1_q;
            end
        end
    end

    assign pipe_io.in_ready  = in_ready;
    assign pipe_io.out_valid = out_valid_q;
    assign pipe_io.out_r     = r_q;
    assign pipe_io.out_tag   = tag2_q;
    assign pipe_io.out_err   = err2_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed bench for mod_addsub_pipe: arithmetic corners, backpressure, range flags, reset.
module tb_mod_addsub_pipe;
    import mod_arith_pkg::*;

    localparam int unsigned W     = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned TAGW  = 4;
    localparam logic [31:0] P     = 32'hFFFF_FFFB;

    localparam logic [127:0] MASK_ALL  = {128{1'b1}};
    localparam logic [127:0] MASK_NO_2 = {32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [127:0] MASK_NO_0 = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mod_addsub_pipe_if #(.W(W), .LANES(LANES), .TAGW(TAGW)) bus ();

    mod_addsub_pipe #(
        .W     (W),
        .P     (P),
        .LANES (LANES),
        .TAGW  (TAGW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pipe_io (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0]        cyc;
        logic [TAGW-1:0]    tag;
        logic [LANES*W-1:0] r;
        logic [LANES-1:0]   err;
    } rx_t;

    rx_t         rx_q[$];
    logic [31:0] cyc_cnt = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Output handshake seen at negedge completes on the following posedge.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready)
            rx_q.push_back({cyc_cnt, bus.out_tag, bus.out_r, bus.out_err});
    end

    function automatic logic [127:0] pk(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [255:0] zpk(input logic [31:0] hi, a0, a1, a2, a3);
        return {hi, a3, hi, a2, hi, a1, hi, a0};
    endfunction

    task automatic drive(input logic op, input logic [3:0] tag, input logic [127:0] f,
                         input logic [255:0] z, input logic [127:0] d);
        bus.in_op    = op;
        bus.in_tag   = tag;
        bus.in_f     = f;
        bus.in_z     = z;
        bus.in_d     = d;
        bus.in_valid = 1'b1;
    endtask

    // Holds the transaction until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input string name, input logic op, input logic [3:0] tag,
                        input logic [127:0] f, input logic [255:0] z, input logic [127:0] d);
        logic acc = 1'b0;
        drive(op, tag, f, z, d);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check_eq({name, " accepted"}, 128'(acc), 128'(1));
    endtask

    task automatic run_one(input string name, input logic op, input logic [3:0] tag,
                           input logic [127:0] f, input logic [255:0] z, input logic [127:0] d,
                           input logic [127:0] exp_r, input logic [127:0] r_mask,
                           input logic [3:0] exp_err);
        send(name, op, tag, f, z, d);
        @(negedge clk);
        check_eq({name, " early valid"}, 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        @(negedge clk);
        check_eq({name, " valid"}, 128'(bus.out_valid), 128'(1));
        check_eq({name, " r"}, bus.out_r & r_mask, exp_r & r_mask);
        check_eq({name, " tag"}, 128'(bus.out_tag), 128'(tag));
        check_eq({name, " err"}, 128'(bus.out_err), 128'(exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        ok;
        int          acc_cnt;
        int          t;
        logic [31:0] pm1;

        pm1           = P - 1;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = OP_SUB;
        bus.in_tag    = '0;
        bus.in_f      = '0;
        bus.in_z      = '0;
        bus.in_d      = '0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        check_eq("reset out_valid", 128'(bus.out_valid), 128'(0));
        check_eq("reset out_r", bus.out_r, 128'(0));
        check_eq("reset out_tag", 128'(bus.out_tag), 128'(0));
        check_eq("reset out_err", 128'(bus.out_err), 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("ready after reset", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;

        run_one("sub wrap", OP_SUB, 4'd1,
                pk(32'd5, 32'd100, 32'd0, pm1), zpk(32'h0, 32'd3, 32'd200, 32'd0, 32'd0),
                pk(32'd10, 32'd50, 32'd0, pm1),
                pk(32'hFFFF_FFF9, 32'hFA, 32'h0, 32'h0), MASK_ALL, 4'b0000);
        run_one("double red sub", OP_SUB, 4'd2,
                pk(pm1, pm1, pm1, pm1), zpk(32'h0, pm1, pm1, pm1, pm1), pk(0, 0, 0, 0),
                pk(32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9), MASK_ALL,
                4'b0000);
        run_one("double red add", OP_ADD, 4'd3,
                pk(pm1, pm1, pm1, pm1), zpk(32'h0, pm1, pm1, pm1, pm1), pk(pm1, pm1, pm1, pm1),
                pk(32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8), MASK_ALL,
                4'b0000);
        run_one("add boundary zhi", OP_ADD, 4'd4,
                pk(pm1, pm1, pm1, pm1), zpk(32'hFFFF_FFFF, 1, 1, 1, 1), pk(pm1, pm1, pm1, pm1),
                pk(32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFA), MASK_ALL,
                4'b0000);
        run_one("range d lane2", OP_SUB, 4'd5,
                pk(7, 7, 7, 7), zpk(32'h0, 8, 8, 8, 8), pk(5, 5, P, 5),
                pk(10, 10, 0, 10), MASK_NO_2, 4'b0100);
        run_one("range z lane0", OP_SUB, 4'd6,
                pk(7, 7, 7, 7), zpk(32'h0, 32'hFFFF_FFFC, 8, 8, 8), pk(5, 5, 5, 5),
                pk(0, 10, 10, 10), MASK_NO_0, 4'b0001);

        // Backpressure: offer tags 1..4 with the sink stalled.
        bus.out_ready = 1'b0;
        rx_q.delete();
        acc_cnt = 0;
        t       = 1;
        drive(OP_ADD, 4'(t), pk(t*16, t*16+1, t*16+2, t*16+3), zpk(32'h0, 0, 0, 0, 0),
              pk(t, t, t, t));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                acc_cnt++;
                t++;
                drive(OP_ADD, 4'(t), pk(t*16, t*16+1, t*16+2, t*16+3),
                      zpk(32'h0, 0, 0, 0, 0), pk(t, t, t, t));
            end
        end
        check_eq("bp accepted", 128'(acc_cnt), 128'(2));
        @(negedge clk);
        check_eq("bp in_ready low", 128'(bus.in_ready), 128'(0));
        check_eq("bp head tag", 128'(bus.out_tag), 128'(1));
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && t <= 4; c++) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (c == 0) check_eq("bp ready return", 128'(ok), 128'(1));
            @(posedge clk);
            #1;
            if (ok) begin
                t++;
                if (t <= 4)
                    drive(OP_ADD, 4'(t), pk(t*16, t*16+1, t*16+2, t*16+3),
                          zpk(32'h0, 0, 0, 0, 0), pk(t, t, t, t));
                else
                    bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 10 && rx_q.size() < 4; c++) @(posedge clk);
        #1;
        check_eq("bp count", 128'(rx_q.size()), 128'(4));
        for (int k = 0; k < 4 && k < rx_q.size(); k++) begin
            check_eq($sformatf("bp tag %0d", k), 128'(rx_q[k].tag), 128'(k + 1));
            check_eq($sformatf("bp r %0d", k), rx_q[k].r,
                     pk((k+1)*17, (k+1)*17+1, (k+1)*17+2, (k+1)*17+3));
            check_eq($sformatf("bp spacing %0d", k), 128'(rx_q[k].cyc - rx_q[0].cyc), 128'(k));
        end

        // Reset with two transactions in flight.
        bus.out_ready = 1'b0;
        rx_q.delete();
        send("flight a", OP_SUB, 4'd9, pk(1, 1, 1, 1), zpk(32'h0, 1, 1, 1, 1), pk(0, 0, 0, 0));
        send("flight b", OP_SUB, 4'd10, pk(2, 2, 2, 2), zpk(32'h0, 2, 2, 2, 2), pk(0, 0, 0, 0));
        @(negedge clk);
        check_eq("flight full valid", 128'(bus.out_valid), 128'(1));
        check_eq("flight full ready", 128'(bus.in_ready), 128'(0));
        #1 reset = 1'b1;
        #1;
        check_eq("async rst valid", 128'(bus.out_valid), 128'(0));
        check_eq("async rst tag", 128'(bus.out_tag), 128'(0));
        check_eq("async rst r", bus.out_r, 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        bus.out_ready = 1'b1;
        run_one("after reset", OP_ADD, 4'd11,
                pk(3, 3, 3, 3), zpk(32'h0, 4, 4, 4, 4), pk(5, 5, 5, 5),
                pk(12, 12, 12, 12), MASK_ALL, 4'b0000);
        repeat (4) @(posedge clk);
        #1;
        check_eq("post reset count", 128'(rx_q.size()), 128'(1));
        if (rx_q.size() > 0) check_eq("post reset tag", 128'(rx_q[0].tag), 128'(11));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
